// File: rtl/regbank_port_arbiter.sv
// Round-robin req/gnt arbiter sharing the register bank's single select/write/read port.
// Define REGARB_WB_PRIORITY_EN to let the writeback requester (index NREQ-1) bypass the round robin.

module regbank_port_arbiter_chk #(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] gnt,
  input  logic [NREQ-1:0] rvalid,
  input  logic            busy,
  input  logic            bank_write
);

  a_gnt_onehot:    assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
  a_rvalid_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(rvalid));
  a_busy_is_gnt:   assert property (@(posedge clk) disable iff (reset) busy == (|gnt));
  a_write_in_acc:  assert property (@(posedge clk) disable iff (reset) bank_write |-> busy);

endmodule

module regbank_port_arbiter #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [NREQ*DATA_W-1:0] wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rvalid,
  output logic [DATA_W-1:0]      rdata,
  output logic                   busy,
  output logic [ADDR_W-1:0]      bank_select,
  output logic                   bank_write,
  output logic [DATA_W-1:0]      bank_dataIn,
  input  logic [DATA_W-1:0]      bank_dataOut
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W:0]   NREQ_W   = (IDX_W + 1)'(NREQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic               rd_pend_r;
  logic [NREQ-1:0]    gnt_r;
  logic [NREQ-1:0]    rvalid_r;
  logic [DATA_W-1:0]  rdata_r;
  logic               busy_r;
  logic [ADDR_W-1:0]  bank_sel_r;
  logic               bank_we_r;
  logic [DATA_W-1:0]  bank_din_r;

  logic [NREQ-1:0]    elig_s;
  logic [2*NREQ-1:0]  dbl_s;
  logic [NREQ-1:0]    rot_s;
  logic               rr_found_s;
  logic [IDX_W-1:0]   off_s;
  logic [IDX_W:0]     sum_s;
  logic [IDX_W-1:0]   rr_win_s;
  logic               found_s;
  logic               prio_s;
  logic [IDX_W-1:0]   win_s;
  logic [IDX_W-1:0]   rr_next_s;
  logic [NREQ-1:0]    win_oh_s;
  logic [ADDR_W-1:0]  win_addr_s;
  logic               win_we_s;
  logic [DATA_W-1:0]  win_wdata_s;

  assign gnt         = gnt_r;
  assign rvalid      = rvalid_r;
  assign rdata       = rdata_r;
  assign busy        = busy_r;
  assign bank_select = bank_sel_r;
  assign bank_write  = bank_we_r;
  assign bank_dataIn = bank_din_r;

  // Round-robin search: rotate so rr_ptr_r sits at bit 0, take the lowest set bit, rotate back.
  // The requester granted this cycle still holds req, so it is masked out.
  always_comb begin
    elig_s     = req & ~gnt_r;
    dbl_s      = {elig_s, elig_s} >> rr_ptr_r;
    rot_s      = dbl_s[NREQ-1:0];
    rr_found_s = |rot_s;
    off_s      = {IDX_W{1'b0}};
    for (int i = NREQ - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? IDX_W'(i) : off_s;
    end
    sum_s    = {1'b0, rr_ptr_r} + {1'b0, off_s};
    rr_win_s = (sum_s >= NREQ_W) ? IDX_W'(sum_s - NREQ_W) : IDX_W'(sum_s);
  end

  // Final winner selection and extraction of the winner's access fields
  always_comb begin
`ifdef REGARB_WB_PRIORITY_EN
    if (elig_s[NREQ-1]) begin
      found_s = 1'b1;
      prio_s  = 1'b1;
      win_s   = LAST_IDX;
    end else begin
      found_s = rr_found_s;
      prio_s  = 1'b0;
      win_s   = rr_win_s;
    end
`else
    found_s = rr_found_s;
    prio_s  = 1'b0;
    win_s   = rr_win_s;
`endif
    rr_next_s   = (win_s == LAST_IDX) ? {IDX_W{1'b0}} : (win_s + ONE_IDX);
    win_oh_s    = {NREQ{1'b0}};
    win_addr_s  = {ADDR_W{1'b0}};
    win_we_s    = 1'b0;
    win_wdata_s = {DATA_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      win_oh_s[i] = (win_s == IDX_W'(i));
      win_addr_s  = win_oh_s[i] ? addr[i*ADDR_W +: ADDR_W]  : win_addr_s;
      win_we_s    = win_oh_s[i] ? we[i]                     : win_we_s;
      win_wdata_s = win_oh_s[i] ? wdata[i*DATA_W +: DATA_W] : win_wdata_s;
    end
  end

  // Access FSM: latch the winner onto the bank port, return read data the cycle after the grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      rr_ptr_r   <= {IDX_W{1'b0}};
      rd_pend_r  <= 1'b0;
      gnt_r      <= {NREQ{1'b0}};
      rvalid_r   <= {NREQ{1'b0}};
      rdata_r    <= {DATA_W{1'b0}};
      busy_r     <= 1'b0;
      bank_sel_r <= {ADDR_W{1'b0}};
      bank_we_r  <= 1'b0;
      bank_din_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ACCESS: begin
          if (rd_pend_r) begin
            rvalid_r <= gnt_r;
            rdata_r  <= bank_dataOut;
          end else begin
            rvalid_r <= {NREQ{1'b0}};
          end
        end
        IDLE: begin
          rvalid_r <= {NREQ{1'b0}};
        end
        default: begin
          rvalid_r <= {NREQ{1'b0}};
        end
      endcase

      if (found_s) begin
        state_r    <= ACCESS;
        gnt_r      <= win_oh_s;
        busy_r     <= 1'b1;
        bank_sel_r <= win_addr_s;
        bank_din_r <= win_wdata_s;
        // x0 is hardwired to zero: the write is granted but never reaches the bank
        bank_we_r  <= win_we_s && (win_addr_s != {ADDR_W{1'b0}});
        rd_pend_r  <= ~win_we_s;
        if (!prio_s) begin
          rr_ptr_r <= rr_next_s;
        end
      end else begin
        state_r   <= IDLE;
        gnt_r     <= {NREQ{1'b0}};
        busy_r    <= 1'b0;
        bank_we_r <= 1'b0;
        rd_pend_r <= 1'b0;
      end
    end
  end

  regbank_port_arbiter_chk #(.NREQ(NREQ)) u_chk (
    .clk        (clk),
    .reset      (reset),
    .gnt        (gnt_r),
    .rvalid     (rvalid_r),
    .busy       (busy_r),
    .bank_write (bank_we_r)
  );

endmodule
